vadd_dma_ctrl: RTL and testbench
================================

Name: vadd_dma_ctrl

Overview:
- Control and datapath sequencer for the 64-bit vector-add ESP accelerator tile.
- On `conf_done` it issues three DMA transactions: read vector A, read vector B, and write A+B back over A.
- It pulses `acc_done` when finished.
- Sits directly on the ESP accelerator socket: conf registers, DMA read/write ctrl and chnl handshakes. Holds one local buffer of `MAX_LEN` 64-bit words.

Parameters:
- `MAX_LEN`, 16, maximum vector length in 64-bit words; local buffer depth.
- `LEN_W`, 32, width of the length/index fields.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `conf_info_reg0`  in  32  base word index of vector A. Vector B is at base+len. Result is written at base.
- `conf_info_reg1`  in  32  vector length `len`, in words.
- `conf_done`  in  1  single-cycle start pulse; conf regs are valid in that cycle.
- `acc_done`  out  1  single-cycle completion pulse.
- `debug`  out  32  status code.
- `dma_read_ctrl_valid`  out  1, `dma_read_ctrl_ready`  in  1.
- `dma_read_ctrl_data_index`  out  32, `dma_read_ctrl_data_length`  out  32, `dma_read_ctrl_data_size`  out  3, `dma_read_ctrl_data_user`  out  6.
- `dma_read_chnl_valid`  in  1, `dma_read_chnl_ready`  out  1, `dma_read_chnl_data`  in  64.
- `dma_write_ctrl_valid`  out  1, `dma_write_ctrl_ready`  in  1.
- `dma_write_ctrl_data_index`  out  32, `dma_write_ctrl_data_length`  out  32, `dma_write_ctrl_data_size`  out  3, `dma_write_ctrl_data_user`  out  6.
- `dma_write_chnl_valid`  out  1, `dma_write_chnl_ready`  in  1, `dma_write_chnl_data`  out  64.

Behaviour:
- Single clock `clk`. Asynchronous active-low reset `rst_n`; reset is fixed as such.
- Reset values:
  - All valid/ready outputs, `acc_done`, `debug`, index, length and data outputs = 0. `user` = 0.
  - State = IDLE; beat counter = 0. Buffer contents undefined.
- Reset mid-operation: immediate return to IDLE. No DMA completion is owed. The next `conf_done` starts fresh.
- Registered config: `conf_info_reg0`/`reg1` are captured in the `conf_done` cycle and are not re-read afterwards.
- Fixed ctrl fields: `data_size` = 3'b011 (64-bit) on both ctrl ports; `data_user` = 0.
- FSM states: IDLE, RD_A_REQ, RD_A_DAT, RD_B_REQ, RD_B_DAT, WR_REQ, WR_DAT, DONE, ERR.
- IDLE:
  - `conf_done` with `len`==0 → DONE (no DMA), `debug`=0.
  - `len`>`MAX_LEN` → ERR.
  - Otherwise → RD_A_REQ.
- ERR: `debug`=32'h1, then → DONE. No DMA issued.
- RD_A_REQ:
  - `dma_read_ctrl_valid`=1, index=base, length=len.
  - Valid asserts the cycle after `conf_done`. Valid and fields stay stable until ready.
  - On valid&ready → RD_A_DAT, counter=0.
- RD_A_DAT:
  - `dma_read_chnl_ready`=1.
  - Each valid&ready beat: `buf[cnt]`<=data, cnt++.
  - After beat `len`-1 → RD_B_REQ. Ready drops in the same cycle the state leaves.
- RD_B_REQ: as RD_A_REQ with index=base+len. The 32-bit add wraps mod 2^32.
- RD_B_DAT: each beat: `buf[cnt]`<=`buf[cnt]`+data, computed mod 2^64 (carry discarded). After beat `len`-1 → WR_REQ.
- WR_REQ: `dma_write_ctrl_valid`=1, index=base, length=len. On handshake → WR_DAT, cnt=0.
- WR_DAT:
  - `dma_write_chnl_valid`=1, data=`buf[cnt]`.
  - Data stays stable while valid&!ready.
  - On handshake cnt++. After beat `len`-1 → DONE.
- DONE: `acc_done`=1 for exactly one cycle → IDLE. `debug` holds until the next `conf_done`, which clears it to 0.
- Ignored inputs:
  - `conf_done` while not IDLE is ignored and `debug`[1] is set (sticky).
  - `dma_read_chnl_valid` outside the *_DAT states is ignored, since ready=0.
- Backpressure: any number of stall cycles on any valid/ready pair is tolerated with no data loss and no duplicate beats.
- At most one ctrl valid is high at any time. Read and write are never concurrent.
- Throughput: one beat per cycle when the peer holds ready/valid high.
- Minimum latency for `len`=N with zero-wait peers: `conf_done` to `acc_done` = 3N+7 cycles.

Test Plan:
- Basic run:
  - Stimulus: mem[0..15]=0..15, mem[16..31]=10..25, reg0=0, reg1=16, zero-wait DMA.
  - Response: read ctrl index 0 then 16, length 16; write index 0, length 16. mem[0..15]=10,12,...,40. One `acc_done` pulse; `debug`=0.
- Back-to-back:
  - Stimulus: repeat the basic run immediately after `acc_done`, with memory reloaded.
  - Response: identical results and a second single `acc_done` pulse.
- Random backpressure:
  - Stimulus: same data, ready/valid randomly deasserted 50% on all ports.
  - Response: same mem result. Ctrl fields and write data stable during stalls. Exactly 16 beats per channel.
- Wrap and offset:
  - Stimulus: A=64'hFFFF_FFFF_FFFF_FFFF, B=2, reg0=8, reg1=1.
  - Response: read indexes 8 and 9; write index 8; result 64'h1.
- Bad and empty length:
  - Stimulus: reg1=17.
  - Response: no DMA valids, `debug`=1, `acc_done` pulse.
  - Stimulus: reg1=0.
  - Response: no DMA, `debug`=0, `acc_done` pulse.
- Reset and spurious start:
  - Stimulus: `rst_n` low during RD_B_DAT.
  - Response: all outputs 0 asynchronously; after release a new run completes correctly.
  - Stimulus: `conf_done` during WR_DAT.
  - Response: ignored, `debug`[1]=1.

Source files
------------

// File: rtl/vadd_dma_ctrl_if.sv
// ----------------------------------------------------------------------------
// vadd_dma_ctrl_if
// DMA side of the ESP accelerator socket used by vadd_dma_ctrl.
//   read ctrl  : valid/ready + index/length/size/user    (request a burst read)
//   read chnl  : valid/ready + 64-bit data               (read data beats)
//   write ctrl : valid/ready + index/length/size/user    (request a burst write)
//   write chnl : valid/ready + 64-bit data               (write data beats)
// Modports:
//   master - accelerator side (issues ctrl requests, sinks read data,
//            sources write data)
//   slave  - DMA engine / memory side
// ----------------------------------------------------------------------------
interface vadd_dma_ctrl_if #(
    parameter int LEN_W = 32
);
    logic             dma_read_ctrl_valid;
    logic             dma_read_ctrl_ready;
    logic [LEN_W-1:0] dma_read_ctrl_data_index;
    logic [LEN_W-1:0] dma_read_ctrl_data_length;
    logic [2:0]       dma_read_ctrl_data_size;
    logic [5:0]       dma_read_ctrl_data_user;

    logic             dma_read_chnl_valid;
    logic             dma_read_chnl_ready;
    logic [63:0]      dma_read_chnl_data;

    logic             dma_write_ctrl_valid;
    logic             dma_write_ctrl_ready;
    logic [LEN_W-1:0] dma_write_ctrl_data_index;
    logic [LEN_W-1:0] dma_write_ctrl_data_length;
    logic [2:0]       dma_write_ctrl_data_size;
    logic [5:0]       dma_write_ctrl_data_user;

    logic             dma_write_chnl_valid;
    logic             dma_write_chnl_ready;
    logic [63:0]      dma_write_chnl_data;

    modport master (
        output dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user,
        input  dma_read_ctrl_ready,
        input  dma_read_chnl_valid, dma_read_chnl_data,
        output dma_read_chnl_ready,
        output dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
        input  dma_write_ctrl_ready,
        output dma_write_chnl_valid, dma_write_chnl_data,
        input  dma_write_chnl_ready
    );

    modport slave (
        input  dma_read_ctrl_valid, dma_read_ctrl_data_index, dma_read_ctrl_data_length,
               dma_read_ctrl_data_size, dma_read_ctrl_data_user,
        output dma_read_ctrl_ready,
        output dma_read_chnl_valid, dma_read_chnl_data,
        input  dma_read_chnl_ready,
        input  dma_write_ctrl_valid, dma_write_ctrl_data_index, dma_write_ctrl_data_length,
               dma_write_ctrl_data_size, dma_write_ctrl_data_user,
        output dma_write_ctrl_ready,
        input  dma_write_chnl_valid, dma_write_chnl_data,
        output dma_write_chnl_ready
    );
endinterface

// File: rtl/vadd_dma_ctrl.sv
// ----------------------------------------------------------------------------
// vadd_dma_ctrl
// Sequencer for the 64-bit vector-add accelerator tile. On conf_done it reads
// vector A (base, len words) into a local buffer, reads vector B (base+len)
// adding it element-wise into the buffer, writes the sums back over A and
// pulses acc_done.
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   conf_info_reg0  - base word index of vector A
//   conf_info_reg1  - vector length in words
//   conf_done       - one-cycle start pulse, conf regs valid in that cycle
//   acc_done        - one-cycle completion pulse
//   debug           - status: bit0 = length out of range, bit1 = start
//                     pulse seen while busy (sticky until next start)
//   dma             - DMA ctrl/chnl handshakes (vadd_dma_ctrl_if.master)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for conf_done
//   RD_A_REQ | read request for vector A on the read ctrl port
//   RD_A_DAT | receiving A beats into the buffer
//   RD_B_REQ | read request for vector B
//   RD_B_DAT | receiving B beats, buffer <= buffer + B
//   WR_REQ   | write request for the result at base
//   WR_DAT   | sending buffer contents on the write channel
//   DONE     | acc_done pulse
//   ERR      | length too large, flag in debug, no DMA
// ----------------------------------------------------------------------------
module vadd_dma_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] conf_info_reg0,
    input  logic [LEN_W-1:0] conf_info_reg1,
    input  logic             conf_done,
    output logic             acc_done,
    output logic [31:0]      debug,
    vadd_dma_ctrl_if.master  dma
);
    localparam int         IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [2:0] SIZE_64 = 3'b011;

    typedef enum logic [3:0] {
        IDLE, RD_A_REQ, RD_A_DAT, RD_B_REQ, RD_B_DAT, WR_REQ, WR_DAT, DONE, ERR
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] base_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem_q;      // beats left after the current one
    logic [IDX_W-1:0] idx_q;      // buffer address of the current beat
    logic             chnl_en_q;  // channel open; low for one turnaround cycle after each ctrl handshake
    logic [31:0]      debug_q;
    logic [63:0]      vbuf_q [MAX_LEN];

    logic ctrl_hs;
    logic rd_beat;
    logic wr_beat;
    logic last_beat;
    logic start;

    assign last_beat = (rem_q == '0);
    assign start     = (state_q == IDLE) && conf_done;
    assign debug     = debug_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_done = 1'b0;
        ctrl_hs  = 1'b0;
        rd_beat  = 1'b0;
        wr_beat  = 1'b0;

        dma.dma_read_ctrl_valid        = 1'b0;
        dma.dma_read_ctrl_data_index   = '0;
        dma.dma_read_ctrl_data_length  = '0;
        dma.dma_read_ctrl_data_size    = SIZE_64;
        dma.dma_read_ctrl_data_user    = '0;
        dma.dma_read_chnl_ready        = 1'b0;
        dma.dma_write_ctrl_valid       = 1'b0;
        dma.dma_write_ctrl_data_index  = '0;
        dma.dma_write_ctrl_data_length = '0;
        dma.dma_write_ctrl_data_size   = SIZE_64;
        dma.dma_write_ctrl_data_user   = '0;
        dma.dma_write_chnl_valid       = 1'b0;
        dma.dma_write_chnl_data        = '0;

        unique case (state_q)
            IDLE: begin
                if (conf_done) begin
                    if (conf_info_reg1 == '0) begin
                        state_d = DONE;
                    end else if (conf_info_reg1 > LEN_W'(MAX_LEN)) begin
                        state_d = ERR;
                    end else begin
                        state_d = RD_A_REQ;
                    end
                end
            end
            RD_A_REQ, RD_B_REQ: begin
                dma.dma_read_ctrl_valid       = 1'b1;
                dma.dma_read_ctrl_data_index  = (state_q == RD_A_REQ) ? base_q : base_q + len_q;
                dma.dma_read_ctrl_data_length = len_q;
                if (dma.dma_read_ctrl_ready) begin
                    ctrl_hs = 1'b1;
                    state_d = (state_q == RD_A_REQ) ? RD_A_DAT : RD_B_DAT;
                end
            end
            RD_A_DAT, RD_B_DAT: begin
                dma.dma_read_chnl_ready = chnl_en_q;
                if (chnl_en_q && dma.dma_read_chnl_valid) begin
                    rd_beat = 1'b1;
                    if (last_beat) begin
                        state_d = (state_q == RD_A_DAT) ? RD_B_REQ : WR_REQ;
                    end
                end
            end
            WR_REQ: begin
                dma.dma_write_ctrl_valid       = 1'b1;
                dma.dma_write_ctrl_data_index  = base_q;
                dma.dma_write_ctrl_data_length = len_q;
                if (dma.dma_write_ctrl_ready) begin
                    ctrl_hs = 1'b1;
                    state_d = WR_DAT;
                end
            end
            WR_DAT: begin
                dma.dma_write_chnl_valid = chnl_en_q;
                if (chnl_en_q) begin
                    dma.dma_write_chnl_data = vbuf_q[idx_q];
                end
                if (chnl_en_q && dma.dma_write_chnl_ready) begin
                    wr_beat = 1'b1;
                    if (last_beat) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                acc_done = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            idx_q     <= '0;
            chnl_en_q <= 1'b0;
            debug_q   <= '0;
        end else begin
            if (start) begin
                base_q <= conf_info_reg0;
                len_q  <= conf_info_reg1;
            end

            if (ctrl_hs) begin
                idx_q     <= '0;
                rem_q     <= len_q - LEN_W'(1);
                chnl_en_q <= 1'b0;
            end else begin
                if (state_q == RD_A_DAT || state_q == RD_B_DAT || state_q == WR_DAT) begin
                    chnl_en_q <= 1'b1;
                end
                if (rd_beat || wr_beat) begin
                    idx_q <= idx_q + IDX_W'(1);
                    rem_q <= rem_q - LEN_W'(1);
                end
            end

            if (start) begin
                debug_q <= '0;
            end else begin
                if (conf_done) begin
                    debug_q[1] <= 1'b1;
                end
                if (state_q == ERR) begin
                    debug_q[0] <= 1'b1;
                end
            end
        end
    end

    // Buffer has no reset; its contents are only read after being written by A.
    always_ff @(posedge clk) begin
        if (rd_beat) begin
            if (state_q == RD_A_DAT) begin
                vbuf_q[idx_q] <= dma.dma_read_chnl_data;
            end else begin
                vbuf_q[idx_q] <= vbuf_q[idx_q] + dma.dma_read_chnl_data;
            end
        end
    end
endmodule

// File: tb/tb_vadd_dma_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vadd_dma_ctrl
// Directed + randomized bench for vadd_dma_ctrl. A DMA peer with a flat
// 256-word memory serves the ctrl/chnl handshakes with random stalls; the
// expected memory image and request list come from a plain A+B model.
// ----------------------------------------------------------------------------
module tb_vadd_dma_ctrl;
    localparam int MAX_LEN = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] conf_info_reg0 = '0;
    logic [31:0] conf_info_reg1 = '0;
    logic        conf_done = 1'b0;
    logic        acc_done;
    logic [31:0] debug;

    vadd_dma_ctrl_if #(.LEN_W(32)) dma_if ();

    vadd_dma_ctrl #(.MAX_LEN(MAX_LEN), .LEN_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .conf_info_reg0 (conf_info_reg0),
        .conf_info_reg1 (conf_info_reg1),
        .conf_done      (conf_done),
        .acc_done       (acc_done),
        .debug          (debug),
        .dma            (dma_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] mem     [256];
    logic [63:0] exp_mem [256];

    int          stall_pct = 0;
    int          rd_left = 0, wr_left = 0;
    logic [7:0]  rd_ptr = '0, wr_ptr = '0;
    int          rd_beats = 0, wr_beats = 0, rd_extra = 0, wr_extra = 0;
    int          done_cnt = 0, done_cyc = 0, dma_cycles = 0;
    int          done0 = 0, start_cyc = 0;
    int          req_kind[$];
    logic [31:0] req_idx[$];
    logic [31:0] req_len[$];
    int          exp_kind[$];
    logic [31:0] exp_idx[$];
    logic [31:0] exp_len[$];

    logic        prev_rc_stall = 1'b0, prev_wc_stall = 1'b0, prev_wd_stall = 1'b0;
    logic [31:0] prev_rc_idx = '0, prev_rc_len = '0, prev_wc_idx = '0, prev_wc_len = '0;
    logic [63:0] prev_wd = '0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic go();
        return ($urandom_range(0, 99) >= stall_pct);
    endfunction

    // DMA peer and monitor; decisions made at the negedge apply to the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            rd_left = 0;
            wr_left = 0;
            dma_if.dma_read_ctrl_ready  = 1'b0;
            dma_if.dma_read_chnl_valid  = 1'b0;
            dma_if.dma_read_chnl_data   = '0;
            dma_if.dma_write_ctrl_ready = 1'b0;
            dma_if.dma_write_chnl_ready = 1'b0;
            prev_rc_stall = 1'b0;
            prev_wc_stall = 1'b0;
            prev_wd_stall = 1'b0;
        end else begin
            if (acc_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (dma_if.dma_read_ctrl_valid || dma_if.dma_write_ctrl_valid ||
                dma_if.dma_write_chnl_valid || dma_if.dma_read_chnl_ready)
                dma_cycles++;
            if (dma_if.dma_read_ctrl_valid || dma_if.dma_write_ctrl_valid)
                check("one_ctrl_valid", dma_if.dma_read_ctrl_valid && dma_if.dma_write_ctrl_valid, 0);

            if (prev_rc_stall)
                check("rd_ctrl_stable",
                      {dma_if.dma_read_ctrl_valid, dma_if.dma_read_ctrl_data_index, dma_if.dma_read_ctrl_data_length},
                      {1'b1, prev_rc_idx, prev_rc_len});
            if (prev_wc_stall)
                check("wr_ctrl_stable",
                      {dma_if.dma_write_ctrl_valid, dma_if.dma_write_ctrl_data_index, dma_if.dma_write_ctrl_data_length},
                      {1'b1, prev_wc_idx, prev_wc_len});
            if (prev_wd_stall)
                check("wr_data_stable", {dma_if.dma_write_chnl_valid, dma_if.dma_write_chnl_data}, {1'b1, prev_wd});

            // read channel: real data while a burst is pending, otherwise stray garbage
            if (rd_left > 0) begin
                dma_if.dma_read_chnl_valid = go();
                dma_if.dma_read_chnl_data  = mem[rd_ptr];
            end else begin
                dma_if.dma_read_chnl_valid = ($urandom_range(0, 3) == 0);
                dma_if.dma_read_chnl_data  = {$urandom, $urandom};
            end
            if (dma_if.dma_read_chnl_valid && dma_if.dma_read_chnl_ready) begin
                if (rd_left > 0) begin
                    rd_ptr++;
                    rd_left--;
                    rd_beats++;
                end else begin
                    rd_extra++;
                end
            end

            dma_if.dma_write_chnl_ready = go();
            if (dma_if.dma_write_chnl_valid && dma_if.dma_write_chnl_ready) begin
                if (wr_left > 0) begin
                    mem[wr_ptr] = dma_if.dma_write_chnl_data;
                    wr_ptr++;
                    wr_left--;
                    wr_beats++;
                end else begin
                    wr_extra++;
                end
            end

            dma_if.dma_read_ctrl_ready = go();
            if (dma_if.dma_read_ctrl_valid && dma_if.dma_read_ctrl_ready) begin
                req_kind.push_back(0);
                req_idx.push_back(dma_if.dma_read_ctrl_data_index);
                req_len.push_back(dma_if.dma_read_ctrl_data_length);
                rd_ptr  = dma_if.dma_read_ctrl_data_index[7:0];
                rd_left = int'(dma_if.dma_read_ctrl_data_length);
            end
            dma_if.dma_write_ctrl_ready = go();
            if (dma_if.dma_write_ctrl_valid && dma_if.dma_write_ctrl_ready) begin
                req_kind.push_back(1);
                req_idx.push_back(dma_if.dma_write_ctrl_data_index);
                req_len.push_back(dma_if.dma_write_ctrl_data_length);
                wr_ptr  = dma_if.dma_write_ctrl_data_index[7:0];
                wr_left = int'(dma_if.dma_write_ctrl_data_length);
            end

            prev_rc_stall = dma_if.dma_read_ctrl_valid && !dma_if.dma_read_ctrl_ready;
            prev_rc_idx   = dma_if.dma_read_ctrl_data_index;
            prev_rc_len   = dma_if.dma_read_ctrl_data_length;
            prev_wc_stall = dma_if.dma_write_ctrl_valid && !dma_if.dma_write_ctrl_ready;
            prev_wc_idx   = dma_if.dma_write_ctrl_data_index;
            prev_wc_len   = dma_if.dma_write_ctrl_data_length;
            prev_wd_stall = dma_if.dma_write_chnl_valid && !dma_if.dma_write_chnl_ready;
            prev_wd       = dma_if.dma_write_chnl_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_outputs_idle(input string pfx);
        check({pfx, "_valids"}, {acc_done, dma_if.dma_read_ctrl_valid, dma_if.dma_read_chnl_ready,
                                 dma_if.dma_write_ctrl_valid, dma_if.dma_write_chnl_valid}, 0);
        check({pfx, "_debug"}, debug, 0);
        check({pfx, "_rd_fields"}, {dma_if.dma_read_ctrl_data_index, dma_if.dma_read_ctrl_data_length}, 0);
        check({pfx, "_wr_fields"}, {dma_if.dma_write_ctrl_data_index, dma_if.dma_write_ctrl_data_length}, 0);
        check({pfx, "_wr_data"}, dma_if.dma_write_chnl_data, 0);
        check({pfx, "_user"}, {dma_if.dma_read_ctrl_data_user, dma_if.dma_write_ctrl_data_user}, 0);
        check({pfx, "_size"}, {dma_if.dma_read_ctrl_data_size, dma_if.dma_write_ctrl_data_size}, 6'b011011);
    endtask

    task automatic load_basic();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 16; i++) begin
            mem[i]      = 64'(i);
            mem[16 + i] = 64'(10 + i);
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    endtask

    // Reference model, then the start pulse; returns one cycle after conf_done.
    task automatic begin_run(input logic [31:0] b, input logic [31:0] l);
        for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
        exp_kind.delete();
        exp_idx.delete();
        exp_len.delete();
        if (l >= 1 && l <= MAX_LEN) begin
            for (int i = 0; i < int'(l); i++)
                exp_mem[8'(b + 32'(i))] = mem[8'(b + 32'(i))] + mem[8'(b + l + 32'(i))];
            exp_kind = '{0, 0, 1};
            exp_idx  = '{b, b + l, b};
            exp_len  = '{l, l, l};
        end
        req_kind.delete();
        req_idx.delete();
        req_len.delete();
        rd_beats = 0;
        wr_beats = 0;
        rd_extra = 0;
        wr_extra = 0;
        dma_cycles = 0;
        done0 = done_cnt;
        conf_info_reg0 = b;
        conf_info_reg1 = l;
        conf_done = 1'b1;
        start_cyc = cyc;
        tick();
        conf_done = 1'b0;
        conf_info_reg0 = $urandom;
        conf_info_reg1 = $urandom;
    endtask

    task automatic finish_run(input string tag, input logic [31:0] l, input logic [31:0] exp_dbg,
                              input bit chk_lat, input int settle);
        int k = 0;
        bit legal;
        legal = (l >= 1 && l <= MAX_LEN);
        while (done_cnt == done0 && k < 4000) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, done_cnt != done0, 1);
        if (chk_lat) check({tag, "_latency"}, done_cyc - start_cyc, 3 * l + 7);
        ticks(settle);
        check({tag, "_done_pulses"}, done_cnt - done0, 1);
        check({tag, "_debug"}, debug, exp_dbg);
        check({tag, "_nreq"}, req_idx.size(), exp_idx.size());
        for (int i = 0; i < exp_idx.size() && i < req_idx.size(); i++)
            check($sformatf("%s_req%0d", tag, i), {32'(req_kind[i]), req_idx[i], req_len[i]},
                  {32'(exp_kind[i]), exp_idx[i], exp_len[i]});
        check({tag, "_rd_beats"}, rd_beats, legal ? 2 * l : 0);
        check({tag, "_wr_beats"}, wr_beats, legal ? l : 0);
        check({tag, "_extra_beats"}, {32'(rd_extra), 32'(wr_extra)}, 0);
        if (!legal) check({tag, "_no_dma"}, dma_cycles, 0);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s_mem%0d", tag, i), mem[i], exp_mem[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, n_err=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        dma_if.dma_read_ctrl_ready  = 1'b0;
        dma_if.dma_read_chnl_valid  = 1'b0;
        dma_if.dma_read_chnl_data   = '0;
        dma_if.dma_write_ctrl_ready = 1'b0;
        dma_if.dma_write_chnl_ready = 1'b0;

        #23;
        check_outputs_idle("reset");
        tick();
        rst_n = 1'b1;
        ticks(2);
        check_outputs_idle("post_reset");

        // basic, zero-wait
        stall_pct = 0;
        load_basic();
        begin_run(0, 16);
        finish_run("basic", 16, 0, 1, 1);
        for (int i = 0; i < 16; i++)
            check($sformatf("basic_sum%0d", i), mem[i], 64'(10 + 2 * i));

        // back-to-back: start pulse in the first IDLE cycle after acc_done
        load_basic();
        begin_run(0, 16);
        finish_run("b2b", 16, 0, 1, 3);

        // 50% backpressure on every handshake
        stall_pct = 50;
        load_basic();
        begin_run(0, 16);
        finish_run("stall", 16, 0, 0, 3);

        // random placement, lengths, data and stall rates
        for (int r = 0; r < 5; r++) begin
            logic [31:0] b, l;
            b = $urandom_range(0, 200);
            l = $urandom_range(1, 16);
            stall_pct = $urandom_range(0, 70);
            load_random();
            begin_run(b, l);
            finish_run($sformatf("rand%0d", r), l, 0, stall_pct == 0, 3);
        end

        // 64-bit wrap at an offset
        stall_pct = 0;
        load_random();
        mem[8] = 64'hFFFF_FFFF_FFFF_FFFF;
        mem[9] = 64'h2;
        begin_run(8, 1);
        finish_run("wrap", 1, 0, 1, 3);
        check("wrap_result", mem[8], 64'h1);

        // bad and empty lengths
        load_random();
        begin_run(5, 17);
        finish_run("len17", 17, 32'h1, 0, 3);
        load_random();
        begin_run(5, 0);
        finish_run("len0", 0, 32'h0, 0, 3);

        // async reset while B is streaming in
        begin
            int k = 0;
            stall_pct = 30;
            load_basic();
            begin_run(0, 16);
            while (rd_beats < 19 && k < 4000) begin
                tick();
                k++;
            end
            check("rst_mid_reached", rd_beats >= 19, 1);
            rst_n = 1'b0;
            #2;
            check_outputs_idle("rst_mid");
            ticks(2);
            rst_n = 1'b1;
            tick();
            check("rst_mid_no_done", done_cnt - done0, 0);
        end
        stall_pct = 0;
        load_basic();
        begin_run(0, 16);
        finish_run("after_rst", 16, 0, 1, 3);

        // spurious start during the write burst
        begin
            int k = 0;
            load_basic();
            begin_run(0, 16);
            while (wr_beats < 2 && k < 4000) begin
                tick();
                k++;
            end
            check("spur_reached", wr_beats >= 2, 1);
            conf_info_reg0 = 40;
            conf_info_reg1 = 3;
            conf_done = 1'b1;
            tick();
            conf_done = 1'b0;
            finish_run("spur", 16, 32'h2, 1, 3);
        end

        // next start clears the sticky flag
        stall_pct = 20;
        load_random();
        begin_run(64, 12);
        finish_run("clear", 12, 0, 0, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
